// File: rtl/subfsm_scheduler.sv
// ----------------------------------------------------------------------------
// subfsm_scheduler
//   Master-level FSM that shares one sub-FSM engine among N_REQ requesters.
//   Round-robin arbitration picks a requester, a one-cycle start pulse kicks
//   the engine, and the FSM waits for the engine's done pulse. A watchdog
//   aborts the run if done does not arrive within TIMEOUT wait cycles.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous reset, active-high
//   req           in   [N_REQ-1:0] level-sensitive request vector
//   sub_done      in   one-cycle completion pulse from the engine
//   grant         out  [N_REQ-1:0] one-hot grant, zero when no run in progress
//   sub_start     out  one-cycle start pulse to the engine
//   active_id     out  [1:0] index of the requester currently or last served
//   timeout_err   out  one-cycle pulse when a run is aborted by the watchdog
//   master_state  out  [2:0] current state encoding, for debug
// ----------------------------------------------------------------------------
module subfsm_scheduler #(
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             sub_done,
    output logic [N_REQ-1:0] grant,
    output logic             sub_start,
    output logic [1:0]       active_id,
    output logic             timeout_err,
    output logic [2:0]       master_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_ARB     = 3'b001,
        S_START   = 3'b010,
        S_WAIT    = 3'b011,
        S_RELEASE = 3'b100,
        S_ERR     = 3'b101
    } state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t           current_state;
    state_t           next_state;
    logic [1:0]       rr_ptr;
    logic [CNT_W-1:0] wd_cnt;
    logic [1:0]       arb_pick;
    logic             arb_any;

    // Round-robin pick: first set request at or above rr_ptr, wrapping mod 4.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        arb_pick = rr_ptr;
        arb_any  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            logic [1:0] idx;
            idx = rr_ptr + 2'(i);
            if (!arb_any && req[idx]) begin
                arb_pick = idx;
                arb_any  = 1'b1;
            end
        end
    end

    always_comb begin
        next_state = S_IDLE;
        case (current_state)
            S_IDLE:    next_state = (|req) ? S_ARB : S_IDLE;
            S_ARB:     next_state = arb_any ? S_START : S_IDLE;
            S_START:   next_state = S_WAIT;
            S_WAIT: begin
                // Done takes priority over an expiring watchdog.
                if (sub_done)               next_state = S_RELEASE;
                else if (wd_cnt == WD_LAST) next_state = S_ERR;
                else                        next_state = S_WAIT;
            end
            S_RELEASE: next_state = S_IDLE;
            S_ERR:     next_state = S_IDLE;
            default:   next_state = S_IDLE;  // unused codes 110/111 recover
        endcase
    end

    // Outputs are decoded from the registered state and registered again, so
    // they trail the state by one cycle and have no path from the inputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            current_state <= S_IDLE;
            rr_ptr        <= '0;
            active_id     <= '0;
            wd_cnt        <= '0;
            grant         <= '0;
            sub_start     <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            current_state <= next_state;

            grant       <= (current_state == S_START || current_state == S_WAIT)
                           ? (N_REQ'(1) << active_id) : '0;
            sub_start   <= (current_state == S_START);
            timeout_err <= (current_state == S_ERR);

            case (current_state)
                S_ARB:     if (arb_any) active_id <= arb_pick;
                S_START:   wd_cnt <= '0;
                S_WAIT:    wd_cnt <= wd_cnt + 1'b1;
                S_RELEASE,
                S_ERR:     rr_ptr <= active_id + 2'd1;
                default:   ;
            endcase
        end
    end

    assign master_state = current_state;

endmodule

// File: tb/tb_subfsm_scheduler.sv
module tb_subfsm_scheduler;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       sub_done;
    logic [3:0] grant;
    logic       sub_start;
    logic [1:0] active_id;
    logic       timeout_err;
    logic [2:0] master_state;

    int checks   = 0;
    int failures = 0;

    // Reference state: the round-robin pointer and the last served index.
    int rr      = 0;
    int last_id = 0;

    subfsm_scheduler #(.N_REQ(4), .CNT_W(8), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .sub_done     (sub_done),
        .grant        (grant),
        .sub_start    (sub_start),
        .active_id    (active_id),
        .timeout_err  (timeout_err),
        .master_state (master_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_winner(input logic [3:0] mask, input int ptr);
        for (int i = 0; i < 4; i++)
            if (mask[(ptr + i) % 4]) return (ptr + i) % 4;
        return -1;
    endfunction

    // One complete run from IDLE. d in 0..TO-1 is the WAIT cycle in which
    // sub_done arrives; d >= TO means the engine never answers.
    task automatic run(input logic [3:0] mask, input int d, input bit noise);
        int         w;
        logic [3:0] oh;
        w  = rr_winner(mask, rr);
        oh = 4'(1 << w);
        req = mask;
        tick();                                   // IDLE sees req
        check("arb_state", 32'(master_state), 32'd1);
        check("arb_grant", 32'(grant), 32'd0);
        tick();                                   // ARB registers winner
        check("start_state", 32'(master_state), 32'd2);
        check("start_id", 32'(active_id), 32'(w));
        check("start_grant", 32'(grant), 32'd0);
        sub_done = noise;                         // must be ignored in START
        req      = 4'($urandom);                  // must be ignored outside IDLE/ARB
        tick();
        sub_done = 1'b0;
        check("grant_on", 32'(grant), 32'(oh));
        check("sub_start_on", 32'(sub_start), 32'd1);
        check("wait_state", 32'(master_state), 32'd3);
        for (int j = 0; j < TO; j++) begin
            if (j == d) sub_done = 1'b1;
            req = 4'($urandom);
            tick();
            sub_done = 1'b0;
            if (j == 0) check("sub_start_pulse", 32'(sub_start), 32'd0);
            if (j == d) begin
                req = 4'b0;
                check("release_state", 32'(master_state), 32'd4);
                check("grant_hold", 32'(grant), 32'(oh));
                tick();
                check("grant_off", 32'(grant), 32'd0);
                check("idle_state", 32'(master_state), 32'd0);
                check("no_timeout", 32'(timeout_err), 32'd0);
                break;
            end
            if (j < TO - 1) begin
                check("wait_hold", 32'(master_state), 32'd3);
                check("wait_grant", 32'(grant), 32'(oh));
            end else begin
                req = 4'b0;
                check("err_state", 32'(master_state), 32'd5);
                check("err_not_yet", 32'(timeout_err), 32'd0);
                tick();
                check("timeout_pulse", 32'(timeout_err), 32'd1);
                check("timeout_grant", 32'(grant), 32'd0);
                check("timeout_idle", 32'(master_state), 32'd0);
                tick();
                check("timeout_end", 32'(timeout_err), 32'd0);
            end
        end
        rr      = (w + 1) % 4;
        last_id = w;
        req     = 4'b0;
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b1111;
        sub_done = 1'b0;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_start", 32'(sub_start), 32'd0);
        check("rst_state", 32'(master_state), 32'd0);
        check("rst_id", 32'(active_id), 32'd0);
        check("rst_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        req = 4'b0;

        // Single requester, then held all-ones rotation.
        run(4'b0100, 4, 1'b0);
        run(4'b1111, 2, 1'b0);
        run(4'b1111, 2, 1'b1);
        run(4'b1111, 2, 1'b0);
        run(4'b1111, 2, 1'b0);
        run(4'b1111, 2, 1'b0);

        // Watchdog abort, then pointer advances past the aborted requester.
        run(4'b0001, TO, 1'b0);
        run(4'b0011, 3, 1'b0);
        // Done coincident with the final watchdog cycle.
        run(4'b1000, TO - 1, 1'b0);
        run(4'b0110, 0, 1'b0);

        // Request withdrawn while in ARB: back to IDLE, active_id unchanged.
        req = 4'b1010;
        tick();
        req = 4'b0;
        tick();
        check("arb_drop_state", 32'(master_state), 32'd0);
        check("arb_drop_id", 32'(active_id), 32'(last_id));
        tick();
        check("arb_drop_idle", 32'(master_state), 32'd0);

        for (int n = 0; n < 40; n++)
            run(4'($urandom_range(1, 15)), int'($urandom_range(0, TO)), 1'($urandom));

        // Reset in the middle of a run.
        req = 4'b1111;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_state", 32'(master_state), 32'd0);
        check("midrst_id", 32'(active_id), 32'd0);
        rst     = 1'b0;
        req     = 4'b0;
        rr      = 0;
        last_id = 0;
        run(4'b1111, 2, 1'b0);
        check("post_rst_id", 32'(last_id), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
